arm_state_snapshot: RTL and testbench

Debug snapshot engine for the ARM core. On a trigger it captures the PC, the full register bus and the full data-memory bus into shadow storage in one cycle. It then streams the captured words out, one per valid/ready handshake. It sits beside the core top level and replaces per-register debug outputs with a single parametrised stream that scales to any register count or memory depth.

---
 rtl/arm_debug_pkg.sv | 38 +++
 rtl/arm_snapshot_trigger.sv | 40 ++++
 rtl/arm_state_snapshot.sv | 156 +++++++++++++++
 tb/tb_arm_state_snapshot.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_debug_pkg.sv
// Shared types and sizing helpers for the ARM debug snapshot engine.
package arm_debug_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } snap_state_e;

   typedef enum logic [1:0] {
      SEC_PC   = 2'd0,
      SEC_REG  = 2'd1,
      SEC_DATA = 2'd2
   } section_e;

   // Number of words in one snapshot: PC, then registers, then data words.
   function automatic int snap_total(input int num_regs, input int data_capacity);
      return 32'sd1 + num_regs + data_capacity;
   endfunction

   // Index width; never below one bit so a single-word snapshot still has a port.
   function automatic int snap_idx_w(input int total);
      return (total > 32'sd1) ? $clog2(total) : 32'sd1;
   endfunction

   // Section that a given snapshot index belongs to.
   function automatic section_e section_of(input int idx, input int num_regs);
      section_e sec;
      if (idx == 32'sd0) begin
         sec = SEC_PC;
      end else if (idx <= num_regs) begin
         sec = SEC_REG;
      end else begin
         sec = SEC_DATA;
      end
      return sec;
   endfunction

endpackage

// File: rtl/arm_snapshot_trigger.sv
// Trigger qualifier: manual request OR rising edge of the PC-match condition.
module arm_snapshot_trigger
   import arm_debug_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_Trigger,
   input  logic                  i_Match_Enable,
   input  logic [DATA_WIDTH-1:0] i_PC,
   input  logic [DATA_WIDTH-1:0] i_Match_PC,
   output logic                  o_Event
);

   logic match_now_s;
   logic match_prev_r;

   // Current match condition and the combined trigger event.
   always_comb begin
      match_now_s = 1'b0;
      o_Event     = 1'b0;
      if (i_Match_Enable && (i_PC == i_Match_PC)) begin
         match_now_s = 1'b1;
      end else begin
         match_now_s = 1'b0;
      end
      o_Event = i_Trigger | (match_now_s & ~match_prev_r);
   end

   // Match history so a PC parked on the match address fires only once.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_prev_r <= 1'b0;
      end else begin
         match_prev_r <= match_now_s;
      end
   end

endmodule

// File: rtl/arm_state_snapshot.sv
// Snapshot engine: captures PC, register bus and data bus in one cycle,
// then streams the frozen copy out over a valid/ready handshake.
module arm_state_snapshot
   import arm_debug_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_REGS      = 16,
   parameter  int DATA_CAPACITY = 16,
   localparam int TOTAL         = snap_total(NUM_REGS, DATA_CAPACITY),
   localparam int IDX_W         = snap_idx_w(TOTAL)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DATA_WIDTH*NUM_REGS-1:0]      i_Register_Bus,
   input  logic [DATA_WIDTH*DATA_CAPACITY-1:0] i_Data_Bus,
   input  logic [DATA_WIDTH-1:0]              i_PC,
   input  logic                              i_Trigger,
   input  logic                              i_Match_Enable,
   input  logic [DATA_WIDTH-1:0]              i_Match_PC,
   input  logic                              i_Ready,
   output logic                              o_Valid,
   output logic [DATA_WIDTH-1:0]              o_Word,
   output logic [IDX_W-1:0]                   o_Index,
   output logic [1:0]                         o_Section,
   output logic                              o_Last,
   output logic                              o_Busy,
   output logic                              o_Overrun,
   output logic [15:0]                        o_Snapshot_Count
);

   // A one-word snapshot is last as soon as it starts.
   localparam logic FIRST_IS_LAST = (TOTAL == 1);

   snap_state_e           state_r;
   logic [DATA_WIDTH-1:0] shadow_r [TOTAL];

   logic                  trig_s;
   logic                  xfer_s;
   logic                  last_xfer_s;
   logic                  capture_s;
   logic [IDX_W-1:0]      next_idx_s;
   logic [DATA_WIDTH-1:0] next_word_s;
   section_e              next_sec_s;
   logic                  next_last_s;

   arm_snapshot_trigger #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trigger (
      .clk            (clk),
      .reset          (reset),
      .i_Trigger      (i_Trigger),
      .i_Match_Enable (i_Match_Enable),
      .i_PC           (i_PC),
      .i_Match_PC     (i_Match_PC),
      .o_Event        (trig_s)
   );

   // Handshake decode and lookahead of the word that follows the current one.
   always_comb begin
      xfer_s      = o_Valid & i_Ready;
      last_xfer_s = xfer_s & o_Last;
      if (state_r == IDLE) begin
         capture_s = trig_s;
      end else begin
         capture_s = trig_s & last_xfer_s;
      end
      next_idx_s  = o_Index + IDX_W'(1'b1);
      next_word_s = shadow_r[next_idx_s];
      next_sec_s  = section_of(int'(next_idx_s), NUM_REGS);
      next_last_s = (next_idx_s == IDX_W'(TOTAL - 1));
   end

   // Freeze PC, registers and data words whenever a trigger is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TOTAL; i++) begin
            shadow_r[i] <= '0;
         end
      end else if (capture_s) begin
         shadow_r[0] <= i_PC;
         for (int r = 0; r < NUM_REGS; r++) begin
            shadow_r[1 + r] <= i_Register_Bus[r*DATA_WIDTH +: DATA_WIDTH];
         end
         for (int d = 0; d < DATA_CAPACITY; d++) begin
            shadow_r[1 + NUM_REGS + d] <= i_Data_Bus[d*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Stream FSM with registered handshake, status and word outputs.
   // Index 0 is always the PC, so on capture it is taken straight from i_PC
   // while the shadow copy is being written on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= IDLE;
         o_Valid          <= 1'b0;
         o_Busy           <= 1'b0;
         o_Last           <= 1'b0;
         o_Overrun        <= 1'b0;
         o_Word           <= '0;
         o_Index          <= '0;
         o_Section        <= SEC_PC;
         o_Snapshot_Count <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (capture_s) begin
                  state_r   <= STREAM;
                  o_Valid   <= 1'b1;
                  o_Busy    <= 1'b1;
                  o_Word    <= i_PC;
                  o_Index   <= '0;
                  o_Section <= SEC_PC;
                  o_Last    <= FIRST_IS_LAST;
               end
            end
            STREAM: begin
               if (last_xfer_s) begin
                  o_Snapshot_Count <= o_Snapshot_Count + 16'd1;
                  if (capture_s) begin
                     o_Word    <= i_PC;
                     o_Index   <= '0;
                     o_Section <= SEC_PC;
                     o_Last    <= FIRST_IS_LAST;
                  end else begin
                     state_r   <= IDLE;
                     o_Valid   <= 1'b0;
                     o_Busy    <= 1'b0;
                     o_Last    <= 1'b0;
                     o_Word    <= '0;
                     o_Index   <= '0;
                     o_Section <= SEC_PC;
                  end
               end else begin
                  if (trig_s) begin
                     o_Overrun <= 1'b1;
                  end
                  if (xfer_s) begin
                     o_Index   <= next_idx_s;
                     o_Word    <= next_word_s;
                     o_Section <= next_sec_s;
                     o_Last    <= next_last_s;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               o_Valid <= 1'b0;
               o_Busy  <= 1'b0;
               o_Last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arm_state_snapshot.sv
// Self-checking bench for arm_state_snapshot: a snapshot-level reference
// model compared every cycle, plus directed literal checks.
module tb_arm_state_snapshot;

   localparam int NR  = 16;
   localparam int DC  = 16;
   localparam int TOT = 1 + NR + DC;

   logic           clk = 1'b0;
   logic           reset;
   logic [511:0]   reg_bus;
   logic [511:0]   data_bus;
   logic [31:0]    pc;
   logic           trig;
   logic           men;
   logic [31:0]    mpc;
   logic           ready;
   logic           valid;
   logic [31:0]    word;
   logic [5:0]     index;
   logic [1:0]     section;
   logic           last;
   logic           busy;
   logic           overrun;
   logic [15:0]    count;

   // small instance: 4 registers, 8 data words
   logic [127:0]   s_reg;
   logic [255:0]   s_data;
   logic [31:0]    s_pc;
   logic           s_trig;
   logic           s_men;
   logic [31:0]    s_mpc;
   logic           s_ready;
   logic           s_valid;
   logic [31:0]    s_word;
   logic [3:0]     s_index;
   logic [1:0]     s_section;
   logic           s_last;
   logic           s_busy;
   logic           s_overrun;
   logic [15:0]    s_count;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   arm_state_snapshot #(.DATA_WIDTH(32), .NUM_REGS(NR), .DATA_CAPACITY(DC)) dut (
      .clk(clk), .reset(reset), .i_Register_Bus(reg_bus), .i_Data_Bus(data_bus),
      .i_PC(pc), .i_Trigger(trig), .i_Match_Enable(men), .i_Match_PC(mpc),
      .i_Ready(ready), .o_Valid(valid), .o_Word(word), .o_Index(index),
      .o_Section(section), .o_Last(last), .o_Busy(busy), .o_Overrun(overrun),
      .o_Snapshot_Count(count)
   );

   arm_state_snapshot #(.DATA_WIDTH(32), .NUM_REGS(4), .DATA_CAPACITY(8)) dut_small (
      .clk(clk), .reset(reset), .i_Register_Bus(s_reg), .i_Data_Bus(s_data),
      .i_PC(s_pc), .i_Trigger(s_trig), .i_Match_Enable(s_men), .i_Match_PC(s_mpc),
      .i_Ready(s_ready), .o_Valid(s_valid), .o_Word(s_word), .o_Index(s_index),
      .o_Section(s_section), .o_Last(s_last), .o_Busy(s_busy), .o_Overrun(s_overrun),
      .o_Snapshot_Count(s_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_busy    = 1'b0;
   int          m_idx     = 0;
   logic [15:0] m_count   = 16'd0;
   bit          m_overrun = 1'b0;
   bit          m_prev    = 1'b0;
   logic [31:0] m_snap [TOT];

   function automatic void model_capture();
      m_snap[0] = pc;
      for (int r = 0; r < NR; r++) m_snap[1 + r] = reg_bus[r*32 +: 32];
      for (int d = 0; d < DC; d++) m_snap[1 + NR + d] = data_bus[d*32 +: 32];
      m_idx  = 0;
      m_busy = 1'b1;
   endfunction

   function automatic logic [1:0] exp_sec(input int i);
      if (i == 0) return 2'd0;
      if (i <= NR) return 2'd1;
      return 2'd2;
   endfunction

   always @(posedge clk) begin : model
      bit match_now;
      bit trig_ev;
      bit accept;
      if (reset) begin
         m_busy = 1'b0; m_idx = 0; m_count = 16'd0; m_overrun = 1'b0; m_prev = 1'b0;
      end else begin
         match_now = men && (pc == mpc);
         trig_ev   = trig || (match_now && !m_prev);
         m_prev    = match_now;
         accept    = m_busy && ready;
         if (!m_busy) begin
            if (trig_ev) model_capture();
         end else if (accept && m_idx == TOT - 1) begin
            m_count = m_count + 16'd1;
            if (trig_ev) model_capture();
            else m_busy = 1'b0;
         end else begin
            if (trig_ev) m_overrun = 1'b1;
            if (accept) m_idx++;
         end
      end
   end

   // every-cycle comparison against the model
   always @(posedge clk) begin : compare
      #1;
      chk("m_valid", 64'(valid), 64'(m_busy));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_overrun", 64'(overrun), 64'(m_overrun));
      chk("m_count", 64'(count), 64'(m_count));
      if (m_busy) begin
         chk("m_word", 64'(word), 64'(m_snap[m_idx]));
         chk("m_index", 64'(index), 64'(m_idx));
         chk("m_section", 64'(section), 64'(exp_sec(m_idx)));
         chk("m_last", 64'(last), 64'(m_idx == TOT - 1));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_idx(input int t, input string nm);
      int n = 0;
      while (!(valid && int'(index) == t) && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(valid && int'(index) == t), 64'd1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (valid && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 64'(valid), 64'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int vcount;
      logic [31:0] held;
      reset = 1'b1; trig = 1'b0; men = 1'b0; mpc = 32'h0; ready = 1'b1; pc = 32'h40;
      for (int r = 0; r < NR; r++) reg_bus[r*32 +: 32] = 32'h1000_0000 + 32'(r);
      for (int d = 0; d < DC; d++) data_bus[d*32 +: 32] = 32'h2000_0000 + 32'(d);
      reg_bus[3*32 +: 32]   = 32'h0000_1234;
      data_bus[15*32 +: 32] = 32'h0000_BEEF;
      s_trig = 1'b0; s_men = 1'b0; s_mpc = 32'h0; s_ready = 1'b1; s_pc = 32'h77;
      for (int r = 0; r < 4; r++) s_reg[r*32 +: 32] = 32'h3000_0000 + 32'(r);
      for (int d = 0; d < 8; d++) s_data[d*32 +: 32] = 32'h4000_0000 + 32'(d);
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_word", 64'(word), 64'd0);
      chk("rst_index", 64'(index), 64'd0);
      chk("rst_section", 64'(section), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // reset in the middle of a stream
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      wait_idx(10, "mid_reach10");
      reset = 1'b1; @(negedge clk);
      chk("mid_valid", 64'(valid), 64'd0);
      chk("mid_index", 64'(index), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_count", 64'(count), 64'd0);
      reset = 1'b0; @(negedge clk);

      // full snapshot with ready held high; live bus change has no effect
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      vcount = 0;
      for (int n = 0; n < 40; n++) begin
         if (n == 1) reg_bus[3*32 +: 32] = 32'hDEAD_0003;
         if (valid) begin
            vcount++;
            if (index == 6'd0) chk("p1_pc", 64'(word), 64'h40);
            if (index == 6'd4) begin
               chk("p1_r3", 64'(word), 64'h1234);
               chk("p1_r3_sec", 64'(section), 64'd1);
            end
            if (index == 6'd32) begin
               chk("p1_d15", 64'(word), 64'hBEEF);
               chk("p1_d15_sec", 64'(section), 64'd2);
               chk("p1_d15_last", 64'(last), 64'd1);
            end
         end
         @(negedge clk);
      end
      chk("p1_vcount", 64'(vcount), 64'd33);
      chk("p1_count", 64'(count), 64'd1);

      // backpressure 1-0-0-1
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      wait_idx(2, "bp_reach2");
      held = word;
      ready = 1'b0; @(negedge clk);
      chk("bp_idx_a", 64'(index), 64'd2);
      chk("bp_word_a", 64'(word), 64'(held));
      @(negedge clk);
      chk("bp_idx_b", 64'(index), 64'd2);
      chk("bp_word_b", 64'(word), 64'(held));
      ready = 1'b1; @(negedge clk);
      chk("bp_idx_c", 64'(index), 64'd3);
      chk("bp_held_val", 64'(held), 64'h1000_0001);
      wait_idle("bp_idle");
      chk("bp_count", 64'(count), 64'd2);
      chk("bp_overrun", 64'(overrun), 64'd0);

      // overrun, then retrigger on the last transfer
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      wait_idx(5, "ov_reach5");
      pc = 32'h99;
      data_bus[15*32 +: 32] = 32'h0000_CAFE;
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      chk("ov_set", 64'(overrun), 64'd1);
      wait_idx(32, "ov_reach32");
      chk("ov_old_d15", 64'(word), 64'hBEEF);
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      chk("rt_valid", 64'(valid), 64'd1);
      chk("rt_index", 64'(index), 64'd0);
      chk("rt_word", 64'(word), 64'h99);
      chk("rt_overrun", 64'(overrun), 64'd1);
      chk("rt_count", 64'(count), 64'd3);
      wait_idle("rt_idle");
      chk("rt_count_end", 64'(count), 64'd4);

      // PC-match trigger: one snapshot for a held match, another after re-arm
      men = 1'b1; mpc = 32'h10; pc = 32'h14; @(negedge clk);
      pc = 32'h10; @(negedge clk);
      vcount = 0;
      for (int n = 0; n < 45; n++) begin
         if (n == 2) pc = 32'h20;
         if (valid) begin
            vcount++;
            if (index == 6'd0) chk("mt_pc", 64'(word), 64'h10);
         end
         @(negedge clk);
      end
      chk("mt_vcount", 64'(vcount), 64'd33);
      chk("mt_count", 64'(count), 64'd5);
      pc = 32'h14; @(negedge clk);
      pc = 32'h10; @(negedge clk);
      chk("mt2_start", 64'(valid), 64'd1);
      wait_idle("mt2_idle");
      chk("mt2_count", 64'(count), 64'd6);
      men = 1'b0;

      // small geometry: 13 words, data section at 5..12
      s_trig = 1'b1; @(negedge clk); s_trig = 1'b0;
      vcount = 0;
      for (int n = 0; n < 20; n++) begin
         if (s_valid) begin
            vcount++;
            if (s_index == 4'd4) begin
               chk("sm_r3", 64'(s_word), 64'h3000_0003);
               chk("sm_r3_sec", 64'(s_section), 64'd1);
            end
            if (s_index == 4'd5) begin
               chk("sm_d0", 64'(s_word), 64'h4000_0000);
               chk("sm_d0_sec", 64'(s_section), 64'd2);
            end
            if (s_index == 4'd11) chk("sm_11_last", 64'(s_last), 64'd0);
            if (s_index == 4'd12) begin
               chk("sm_d7", 64'(s_word), 64'h4000_0007);
               chk("sm_d7_sec", 64'(s_section), 64'd2);
               chk("sm_12_last", 64'(s_last), 64'd1);
            end
         end
         @(negedge clk);
      end
      chk("sm_vcount", 64'(vcount), 64'd13);
      chk("sm_count", 64'(s_count), 64'd1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
